// File: rtl/reg_serializer_pkg.sv
// Shared definitions for the register serializer: default word width and FSM state encodings.
package reg_serializer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/reg_serializer_bit_counter.sv
// Frame bit counter: counts 0..WIDTH-1 and flags the last bit of a frame.
module bit_counter
    import reg_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count;

    // Clear wins over enable so the count restarts cleanly at the end of every frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/reg_serializer.sv
// Parallel-in / serial-out transmitter: captures a word on an accepted load and shifts it out one bit per clock.
module reg_serializer
    import reg_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             tc;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    always_comb begin
        shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state != SHIFT) || tc),
        .enable (state == SHIFT),
        .tc     (tc)
    );

    // sout is registered from the next shift value so it always shows the bit currently in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            out        <= '0;
            ready      <= 1'b1;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load && ready) begin
                        state      <= SHIFT;
                        shreg      <= in;
                        out        <= in;
                        ready      <= 1'b0;
                        sout_valid <= 1'b1;
                        sout       <= head_bit(in);
                    end
                end
                SHIFT: begin
                    if (tc) begin
                        state      <= DONE;
                        shreg      <= '0;
                        sout_valid <= 1'b0;
                        sout       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        shreg <= shreg_next;
                        sout  <= head_bit(shreg_next);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    shreg      <= '0;
                    ready      <= 1'b1;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
